// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and constants for the core_ctrl sequencer.
//   state_t       sequencer states
//   B_*           bit positions of the 34-bit core instruction word
//   INST_NOP      idle instruction (both memories disabled, no strobes)
//   W_BASE        xmem base address of the weight region
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_GAP, S_W_LOAD, S_A_L0, S_EXEC, S_DRAIN,
    S_OFIFO, S_ACC_CLR, S_ACC_RD, S_ACC_OUT, S_DONE
  } state_t;

  localparam int INST_W     = 34;
  localparam int ADDR_W     = 11;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LO    = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LO    = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // CEN/WEN of pmem (32,31) and xmem (19,18) high, everything else low
  localparam logic [INST_W-1:0] INST_NOP = 34'h1_800C_0000;
  localparam logic [ADDR_W-1:0] W_BASE   = 11'd1024;

endpackage

// File: rtl/core_ctrl_agen.sv
// core_ctrl_agen: psum address for accumulating output pixel o from kernel
// position k:  k*len_nij + (o/onij_w + k/ker_w)*nij_w + (o%onij_w + k%ker_w).
// Purely combinational; the caller registers the result inside inst.
//   o     in  4   output pixel index
//   k     in  4   kernel position index
//   addr  out 11  pmem read address
module core_ctrl_agen #(
  parameter int len_nij = 36,
  parameter int nij_w   = 6,
  parameter int onij_w  = 4,
  parameter int ker_w   = 3
) (
  input  logic [3:0]  o,
  input  logic [3:0]  k,
  output logic [10:0] addr
);

  logic [3:0] oy, ox, ky, kx;

  always_comb begin
    oy   = o / 4'(onij_w);
    ox   = o % 4'(onij_w);
    ky   = k / 4'(ker_w);
    kx   = k % 4'(ker_w);
    addr = 11'(k) * 11'(len_nij) + (11'(oy) + 11'(ky)) * 11'(nij_w)
         + 11'(ox) + 11'(kx);
  end

endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: fixed-schedule sequencer driving the 34-bit inst bus of core.
// Per kernel position: weights -> L0, load PEs, activations -> L0, execute,
// drain, OFIFO -> pmem. Then every output pixel is accumulated via the SFP.
//   clk          in   1   clock
//   reset        in   1   async, active high
//   start        in   1   run request, honoured only in IDLE
//   ofifo_valid  in   1   OFIFO has data (used only with the macro below)
//   inst         out  34  registered instruction word
//   acc_clr      out  1   SFP clear before each output pixel
//   out_valid    out  1   sfp_out holds pixel `onij`
//   onij         out  4   output pixel index
//   busy         out  1   not in IDLE
//   done         out  1   end-of-run pulse
// Build option: CORE_CTRL_OFIFO_HS_EN gates OFIFO reads with ofifo_valid and
// holds OFIFO until all len_nij words are written.
//
// Every output is a register loaded from the *next* state decode, so inst
// is aligned with the state register. Delayed strobes (l0_wr, pmem write,
// acc) are taken straight from the previous inst word, which gives the
// one-cycle lag by construction. gap must be >= 1.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int gap      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              acc_clr,
  output logic              out_valid,
  output logic [3:0]        onij,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] C_COL  = 8'(col);
  localparam logic [7:0] C_NIJ  = 8'(len_nij);
  localparam logic [7:0] C_KIJ  = 8'(len_kij);
  localparam logic [7:0] C_DRN  = 8'(row + col - 1);
  localparam logic [7:0] C_GAP  = 8'(gap - 1);
  localparam logic [3:0] K_LAST = 4'(len_kij - 1);
  localparam logic [3:0] O_LAST = 4'(len_onij - 1);

  state_t             st, st_n, ret, ret_n;
  logic [7:0]         cnt, cnt_n, wcnt, wcnt_n;
  logic [3:0]         kij, kij_n, onij_n;
  logic [INST_W-1:0]  inst_d;
  logic [ADDR_W-1:0]  acc_addr;
  logic               rd_en;

`ifdef CORE_CTRL_OFIFO_HS_EN
  assign rd_en = ofifo_valid;
`else
  logic unused_ofifo_valid;
  assign unused_ofifo_valid = ofifo_valid;
  assign rd_en = 1'b1;
`endif

  core_ctrl_agen #(.len_nij(len_nij)) u_agen (
    .o    (onij_n),
    .k    (cnt_n[3:0]),
    .addr (acc_addr)
  );

  // next state / counters
  always_comb begin
    st_n   = st;
    ret_n  = ret;
    cnt_n  = cnt + 8'd1;
    kij_n  = kij;
    onij_n = onij;
    case (st)
      S_IDLE: begin
        cnt_n  = '0;
        kij_n  = '0;
        onij_n = '0;
        if (start) st_n = S_W_L0;
      end
      S_W_L0:   if (cnt == C_COL) begin st_n = S_GAP; ret_n = S_W_LOAD; cnt_n = '0; end
      S_GAP:    if (cnt == C_GAP) begin st_n = ret; cnt_n = '0; end
      S_W_LOAD: if (cnt == C_COL - 8'd1) begin st_n = S_GAP; ret_n = S_A_L0; cnt_n = '0; end
      S_A_L0:   if (cnt == C_NIJ) begin st_n = S_GAP; ret_n = S_EXEC; cnt_n = '0; end
      S_EXEC:   if (cnt == C_NIJ - 8'd1) begin st_n = S_DRAIN; cnt_n = '0; end
      S_DRAIN:  if (cnt == C_DRN) begin st_n = S_OFIFO; cnt_n = '0; end
      S_OFIFO: begin
        // cnt = reads issued before this cycle; leave once the last write shows
        cnt_n = cnt + 8'(inst[B_OFIFO_RD]);
        if (wcnt == C_NIJ) begin
          cnt_n = '0;
          if (kij == K_LAST) st_n = S_ACC_CLR;
          else begin
            kij_n = kij + 4'd1;
            st_n  = S_W_L0;
          end
        end
      end
      S_ACC_CLR: begin st_n = S_ACC_RD; cnt_n = '0; end
      S_ACC_RD:  if (cnt == C_KIJ) begin st_n = S_ACC_OUT; cnt_n = '0; end
      S_ACC_OUT: begin
        cnt_n = '0;
        if (onij == O_LAST) begin
          st_n   = S_DONE;
          onij_n = '0;
        end else begin
          onij_n = onij + 4'd1;
          st_n   = S_ACC_CLR;
        end
      end
      S_DONE: begin
        cnt_n = '0;
        kij_n = '0;
        st_n  = S_IDLE;
      end
      default: st_n = S_IDLE;
    endcase
  end

  // instruction decode of the upcoming cycle
  always_comb begin
    inst_d = INST_NOP;
    case (st_n)
      S_W_L0: if (cnt_n < C_COL) begin
        inst_d[B_CEN_X] = 1'b0;
        inst_d[B_AX_LO +: ADDR_W] = W_BASE + 11'(kij_n) * 11'(col) + 11'(cnt_n);
      end
      S_W_LOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
      end
      S_A_L0: if (cnt_n < C_NIJ) begin
        inst_d[B_CEN_X] = 1'b0;
        inst_d[B_AX_LO +: ADDR_W] = 11'(cnt_n);
      end
      S_EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
      end
      S_OFIFO:  if (cnt_n < C_NIJ) inst_d[B_OFIFO_RD] = rd_en;
      S_ACC_RD: if (cnt_n < C_KIJ) begin
        inst_d[B_CEN_P] = 1'b0;
        inst_d[B_AP_LO +: ADDR_W] = acc_addr;
      end
      default: ;
    endcase
    // strobes that follow last cycle's read
    if (!inst[B_CEN_X]) inst_d[B_L0_WR] = 1'b1;
    if (inst[B_OFIFO_RD]) begin
      inst_d[B_CEN_P] = 1'b0;
      inst_d[B_WEN_P] = 1'b0;
      inst_d[B_AP_LO +: ADDR_W] = 11'(kij) * 11'(len_nij) + 11'(wcnt);
    end
    if (!inst[B_CEN_P] && inst[B_WEN_P]) inst_d[B_ACC] = 1'b1;
  end

  // wcnt = pmem writes shown so far in this OFIFO phase
  always_comb begin
    wcnt_n = '0;
    if (st_n == S_OFIFO) wcnt_n = wcnt + 8'(inst[B_OFIFO_RD]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= S_IDLE;
      ret       <= S_IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      kij       <= '0;
      onij      <= '0;
      inst      <= INST_NOP;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      st        <= st_n;
      ret       <= ret_n;
      cnt       <= cnt_n;
      wcnt      <= wcnt_n;
      kij       <= kij_n;
      onij      <= onij_n;
      inst      <= inst_d;
      acc_clr   <= (st_n == S_ACC_CLR);
      out_valid <= (st_n == S_ACC_OUT);
      busy      <= (st_n != S_IDLE);
      done      <= (st_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl. Cycle 1 is the first cycle after the start
// pulse. Field positions and expected schedule are written out by hand.
module tb_core_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [33:0] inst;
  logic        acc_clr, out_valid, busy, done;
  logic [3:0]  onij;

  core_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .acc_clr(acc_clr), .out_valid(out_valid), .onij(onij),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [33:0] NOP = 34'h1_800C_0000;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_load, n_exec, n_l0wr, n_acc, n_clr, n_done, busy_low;
  int first_load, first_exec, first_l0wr, first_clr, last_w, last_ov, done_cyc;
  int xq[$], wq[$], rq[$], ovq[$];
  int acc0[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};

  task automatic clr_stats();
    n_load = 0; n_exec = 0; n_l0wr = 0; n_acc = 0; n_clr = 0; n_done = 0;
    busy_low = 0; first_load = -1; first_exec = -1; first_l0wr = -1;
    first_clr = -1; last_w = -1; last_ov = -1; done_cyc = -1;
    xq.delete(); wq.delete(); rq.delete(); ovq.delete();
  endtask

  // steps n cycles from a negedge, recording what inst and the flags show
  task automatic collect(input int n, input int drop_from, input int drop_len, input int start_at);
    for (int i = 0; i < n; i++) begin
      ofifo_valid = !(i >= drop_from && i < drop_from + drop_len);
      start = (i == start_at);
      @(negedge clk); cyc++;
      if (inst[0]) begin n_load++; if (first_load < 0) first_load = cyc; end
      if (inst[1]) begin n_exec++; if (first_exec < 0) first_exec = cyc; end
      if (inst[2]) begin n_l0wr++; if (first_l0wr < 0) first_l0wr = cyc; end
      if (!inst[19]) xq.push_back(int'(inst[17:7]));
      if (!inst[32] && !inst[31]) begin wq.push_back(int'(inst[30:20])); last_w = cyc; end
      if (!inst[32] && inst[31]) rq.push_back(int'(inst[30:20]));
      if (inst[33]) n_acc++;
      if (acc_clr) begin n_clr++; if (first_clr < 0) first_clr = cyc; end
      if (out_valid) begin ovq.push_back(int'(onij)); last_ov = cyc; end
      if (done) begin n_done++; done_cyc = cyc; end
      if (!busy) busy_low++;
    end
    start = 1'b0; ofifo_valid = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", inst, NOP); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if ({acc_clr, out_valid, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {acc_clr, out_valid, done}); end
    n_chk++; if (onij !== 4'd0) begin n_fail++; $display("FAIL reset_onij: got %0d want 0", onij); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    pulse_start();
    n_chk++; if (inst[17:7] !== 11'd1024) begin n_fail++; $display("FAIL start_axmem: got %0d want 1024", inst[17:7]); end
    n_chk++; if (inst[19:18] !== 2'b01) begin n_fail++; $display("FAIL start_cen_wen: got %b want 01", inst[19:18]); end
    n_chk++; if (inst[2] !== 1'b0) begin n_fail++; $display("FAIL start_l0wr: got %b want 0", inst[2]); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
  endtask

  task automatic test_kij0();
    int bad = 0;
    clr_stats();
    collect(148, 9999, 0, -1);   // cycles 2..149
    n_chk++; if (first_l0wr != 2) begin n_fail++; $display("FAIL k0_first_l0wr: got %0d want 2", first_l0wr); end
    n_chk++; if (n_l0wr != 44) begin n_fail++; $display("FAIL k0_l0wr_cnt: got %0d want 44", n_l0wr); end
    n_chk++; if (first_load != 12) begin n_fail++; $display("FAIL k0_first_load: got %0d want 12", first_load); end
    n_chk++; if (n_load != 8) begin n_fail++; $display("FAIL k0_load_cnt: got %0d want 8", n_load); end
    n_chk++; if (first_exec != 61) begin n_fail++; $display("FAIL k0_first_exec: got %0d want 61", first_exec); end
    n_chk++; if (n_exec != 36) begin n_fail++; $display("FAIL k0_exec_cnt: got %0d want 36", n_exec); end
    n_chk++; if (xq.size() != 43) begin n_fail++; $display("FAIL k0_xmem_reads: got %0d want 43", xq.size()); end
    n_chk++; if (xq[6] != 1031 || xq[7] != 0 || xq[42] != 35) begin n_fail++; $display("FAIL k0_xmem_addr: got %0d %0d %0d want 1031 0 35", xq[6], xq[7], xq[42]); end
    for (int i = 0; i < 36; i++) if (wq[i] != i) bad++;
    n_chk++; if (wq.size() != 36 || bad != 0) begin n_fail++; $display("FAIL k0_pmem_wr: got %0d writes %0d misplaced want 36 0", wq.size(), bad); end
    n_chk++; if (last_w != 149) begin n_fail++; $display("FAIL k0_last_wr_cyc: got %0d want 149", last_w); end
  endtask

  task automatic test_midrun_start();
    clr_stats();
    collect(1043, 9999, 0, 400);  // kij 1..7, cycles 150..1192
    n_chk++; if (xq[0] != 1032) begin n_fail++; $display("FAIL k1_first_w: got %0d want 1032", xq[0]); end
    n_chk++; if (busy_low != 0) begin n_fail++; $display("FAIL mid_busy_low: got %0d want 0", busy_low); end
    n_chk++; if (wq.size() != 252 || wq[0] != 36 || wq[251] != 287) begin n_fail++; $display("FAIL mid_pmem: got %0d %0d %0d want 252 36 287", wq.size(), wq[0], wq[251]); end
    n_chk++; if (n_exec != 252) begin n_fail++; $display("FAIL mid_exec: got %0d want 252", n_exec); end
  endtask

  task automatic test_kij8();
    int bad = 0;
    clr_stats();
    collect(149, 9999, 0, -1);   // cycles 1193..1341
    for (int i = 0; i < 8; i++) if (xq[i] != 1088 + i) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL k8_waddr: got %0d bad, first %0d want 0 bad, first 1088", bad, xq[0]); end
    n_chk++; if (wq.size() != 36 || wq[0] != 288 || wq[35] != 323) begin n_fail++; $display("FAIL k8_pmem: got %0d %0d %0d want 36 288 323", wq.size(), wq[0], wq[35]); end
    n_chk++; if (busy_low != 0) begin n_fail++; $display("FAIL k8_busy: got %0d low want 0", busy_low); end
    n_chk++; if (last_w != 1341) begin n_fail++; $display("FAIL k8_last_wr_cyc: got %0d want 1341", last_w); end
  endtask

  task automatic test_accum();
    int bad = 0;
    clr_stats();
    collect(194, 9999, 0, -1);   // cycles 1342..1535
    n_chk++; if (first_clr != 1342 || n_clr != 16) begin n_fail++; $display("FAIL acc_clr: got cyc %0d cnt %0d want 1342 16", first_clr, n_clr); end
    for (int i = 0; i < 9; i++) if (rq[i] != acc0[i]) bad++;
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL acc_o0_addr: got %0d bad (rq[3]=%0d) want 0 (114)", bad, rq[3]); end
    n_chk++; if (rq.size() != 144 || rq[45] != 7 || rq[53] != 309) begin n_fail++; $display("FAIL acc_o5_addr: got %0d %0d %0d want 144 7 309", rq.size(), rq[45], rq[53]); end
    n_chk++; if (n_acc != 144) begin n_fail++; $display("FAIL acc_cnt: got %0d want 144", n_acc); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ovq[i] != i) bad++;
    n_chk++; if (ovq.size() != 16 || ovq[5] != 5 || bad != 0) begin n_fail++; $display("FAIL out_valid: got %0d pulses onij5=%0d bad %0d want 16 5 0", ovq.size(), ovq[5], bad); end
    n_chk++; if (last_ov != 1533) begin n_fail++; $display("FAIL last_ov_cyc: got %0d want 1533", last_ov); end
    n_chk++; if (n_done != 1 || done_cyc != 1534) begin n_fail++; $display("FAIL done: got %0d at %0d want 1 at 1534", n_done, done_cyc); end
    n_chk++; if (busy !== 1'b0 || busy_low != 1) begin n_fail++; $display("FAIL end_busy: got %b low %0d want 0 1", busy, busy_low); end
  endtask

  task automatic test_reset_exec();
    pulse_start();
    clr_stats();
    collect(69, 9999, 0, -1);    // cycles 2..70
    n_chk++; if (inst[1] !== 1'b1) begin n_fail++; $display("FAIL rx_in_exec: got %b want 1", inst[1]); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (inst !== NOP || busy !== 1'b0) begin n_fail++; $display("FAIL rx_nop: got %h busy %b want %h 0", inst, busy, NOP); end
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    n_chk++; if (inst[17:7] !== 11'd1024 || inst[19] !== 1'b0) begin n_fail++; $display("FAIL rx_restart: got %0d cen %b want 1024 0", inst[17:7], inst[19]); end
    clr_stats();
    collect(148, 9999, 0, -1);
    n_chk++; if (wq.size() != 36 || wq[0] != 0 || wq[35] != 35 || n_load != 8) begin n_fail++; $display("FAIL rx_kij0: got %0d %0d %0d load %0d want 36 0 35 8", wq.size(), wq[0], wq[35], n_load); end
  endtask

`ifdef CORE_CTRL_OFIFO_HS_EN
  task automatic test_hs();
    int bad = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    clr_stats();
    collect(154, 119, 5, -1);    // ofifo_valid low on cycles 120..124
    for (int i = 0; i < 36; i++) if (wq[i] != i) bad++;
    n_chk++; if (wq.size() != 36 || bad != 0) begin n_fail++; $display("FAIL hs_pmem: got %0d writes %0d bad want 36 0", wq.size(), bad); end
    n_chk++; if (last_w != 154) begin n_fail++; $display("FAIL hs_last_wr: got %0d want 154", last_w); end
    n_chk++; if (xq.size() != 44 || xq[43] != 1032) begin n_fail++; $display("FAIL hs_next_kij: got %0d %0d want 44 1032", xq.size(), xq[43]); end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_kij0();
    test_midrun_start();
    test_kij8();
    test_accum();
    test_reset_exec();
`ifdef CORE_CTRL_OFIFO_HS_EN
    test_hs();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
